mc_control: RTL

- Multi-cycle MIPS control unit; successor to the single-cycle decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and issues one-cycle write strobes to PC, IR, GPR and DM.
- Supports parametrised wait states for instruction and data memory.
- Sits between the IR opcode/funct fields, the ALU zero flag, and the multi-cycle datapath muxes.

---
 rtl/mc_control_if.sv | 32 +++
 rtl/mc_control.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mc_control_if.sv
// Signal bundle between the multi-cycle control unit and its datapath/IR.
// The slave modport is the control unit's view; the master modport is the datapath's view.
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we;
  logic       ir_we;
  logic       reg_we;
  logic       mem_we;
  logic [1:0] reg_dst;
  logic       alu_src;
  logic [1:0] mem_to_reg;
  logic [1:0] ext_op;
  logic [2:0] alu_ctr;
  logic [1:0] npc_sel;
  logic [2:0] state;
  logic       illegal;
  logic       halted;

  modport slave (
    input  opcode, funct, zero,
    output pc_we, ir_we, reg_we, mem_we, reg_dst, alu_src, mem_to_reg,
           ext_op, alu_ctr, npc_sel, state, illegal, halted
  );

  modport master (
    output opcode, funct, zero,
    input  pc_we, ir_we, reg_we, mem_we, reg_dst, alu_src, mem_to_reg,
           ext_op, alu_ctr, npc_sel, state, illegal, halted
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with instruction/data memory wait states.
// Optional macro ILLEGAL_HALT_EN: an illegal instruction parks the FSM in HALT until reset.
module mc_control #(
  parameter int unsigned FETCH_WAIT = 0,
  parameter int unsigned MEM_WAIT   = 0,
  parameter int unsigned WAIT_W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [WAIT_W-1:0] C_FW  = WAIT_W'(FETCH_WAIT);
  localparam logic [WAIT_W-1:0] C_MW  = WAIT_W'(MEM_WAIT);
  localparam logic [WAIT_W-1:0] C_ONE = WAIT_W'(1);

  state_t            r_state, w_next;
  logic [WAIT_W-1:0] r_cnt;

  logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal, w_legal;
  logic w_pc_we, w_ir_we, w_reg_we, w_mem_we, w_illegal;

  assign w_rtype = (bus.opcode == 6'd0);
  assign w_addu  = w_rtype && (bus.funct == 6'd33);
  assign w_subu  = w_rtype && (bus.funct == 6'd35);
  assign w_jr    = w_rtype && (bus.funct == 6'd8);
  assign w_ori   = (bus.opcode == 6'd13);
  assign w_lw    = (bus.opcode == 6'd35);
  assign w_sw    = (bus.opcode == 6'd43);
  assign w_beq   = (bus.opcode == 6'd4);
  assign w_lui   = (bus.opcode == 6'd15);
  assign w_j     = (bus.opcode == 6'd2);
  assign w_jal   = (bus.opcode == 6'd3);
  assign w_legal = w_addu | w_subu | w_jr | w_ori | w_lw | w_sw | w_beq | w_lui | w_j | w_jal;

  // Datapath mux selects depend only on the instruction, never on the state
  always_comb begin
    bus.reg_dst    = 2'd0;
    bus.alu_src    = 1'b0;
    bus.mem_to_reg = 2'd0;
    bus.ext_op     = 2'd0;
    bus.alu_ctr    = 3'd0;
    bus.npc_sel    = 2'd0;
    if (w_addu) begin
      bus.reg_dst = 2'd1; bus.alu_ctr = 3'd1;
    end else if (w_subu) begin
      bus.reg_dst = 2'd1; bus.alu_ctr = 3'd2;
    end else if (w_ori) begin
      bus.alu_src = 1'b1; bus.alu_ctr = 3'd3;
    end else if (w_lui) begin
      bus.alu_src = 1'b1; bus.ext_op = 2'd2; bus.alu_ctr = 3'd4;
    end else if (w_lw) begin
      bus.alu_src = 1'b1; bus.ext_op = 2'd1; bus.alu_ctr = 3'd1; bus.mem_to_reg = 2'd1;
    end else if (w_sw) begin
      bus.alu_src = 1'b1; bus.ext_op = 2'd1; bus.alu_ctr = 3'd1;
    end else if (w_beq) begin
      bus.ext_op = 2'd1; bus.alu_ctr = 3'd2; bus.npc_sel = 2'd1;
    end else if (w_j) begin
      bus.npc_sel = 2'd2;
    end else if (w_jal) begin
      bus.npc_sel = 2'd2; bus.reg_dst = 2'd2; bus.mem_to_reg = 2'd2;
    end else if (w_jr) begin
      bus.npc_sel = 2'd3;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_pc_we   = 1'b0;
    w_ir_we   = 1'b0;
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (r_cnt == C_FW) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_j || w_jr) begin
          w_pc_we = 1'b1;
          w_next  = S_FETCH;
        end else if (w_jal) begin
          w_pc_we  = 1'b1;
          w_reg_we = 1'b1;
          w_next   = S_FETCH;
        end else if (!w_legal) begin
          w_illegal = 1'b1;
`ifdef ILLEGAL_HALT_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
`endif
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_beq) begin
          w_pc_we = bus.zero;
          w_next  = S_FETCH;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (r_cnt == C_MW) begin
          if (w_sw) begin
            w_mem_we = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_next   = S_FETCH;
      end
`ifdef ILLEGAL_HALT_EN
      S_HALT:  w_next = S_HALT;
`else
      S_HALT:  w_next = S_FETCH;
`endif
      default: w_next = S_FETCH;
    endcase
    // Reset dominates: a pending sw in MEM must not issue its write
    if (reset) begin
      w_pc_we   = 1'b0;
      w_ir_we   = 1'b0;
      w_reg_we  = 1'b0;
      w_mem_we  = 1'b0;
      w_illegal = 1'b0;
      w_next    = S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    r_state <= w_next;
    if (reset || (w_next != r_state)) begin
      r_cnt <= '0;
    end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  assign bus.pc_we   = w_pc_we;
  assign bus.ir_we   = w_ir_we;
  assign bus.reg_we  = w_reg_we;
  assign bus.mem_we  = w_mem_we;
  assign bus.illegal = w_illegal;
  assign bus.state   = r_state;
`ifdef ILLEGAL_HALT_EN
  assign bus.halted  = (r_state == S_HALT);
`else
  assign bus.halted  = 1'b0;
`endif

endmodule
